// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-stage state encoding and the field layout
// of every inter-stage bundle (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // IF/ID: PC+4, Instr
    localparam int unsigned IFID_W          = 64;
    localparam int unsigned IFID_PC4_LSB    = 32;
    localparam int unsigned IFID_PC4_W      = 32;
    localparam int unsigned IFID_INSTR_LSB  = 0;
    localparam int unsigned IFID_INSTR_W    = 32;

    // ID/EX: 9 control bits, PC+4, Rdata1, Rdata2, Imm, Rt, Rd
    localparam int unsigned IDEX_W          = 147;
    localparam int unsigned IDEX_CTRL_LSB   = 138;
    localparam int unsigned IDEX_CTRL_W     = 9;
    localparam int unsigned IDEX_PC4_LSB    = 106;
    localparam int unsigned IDEX_RDATA1_LSB = 74;
    localparam int unsigned IDEX_RDATA2_LSB = 42;
    localparam int unsigned IDEX_IMM_LSB    = 10;
    localparam int unsigned IDEX_RT_LSB     = 5;
    localparam int unsigned IDEX_RD_LSB     = 0;
    localparam int unsigned IDEX_REG_W      = 5;

    // EX/MEM: 6 control bits (incl. Zero), branch target, ALUresult, write data, Reg_Dst
    localparam int unsigned EXMEM_W          = 107;
    localparam int unsigned EXMEM_CTRL_LSB   = 101;
    localparam int unsigned EXMEM_CTRL_W     = 6;
    localparam int unsigned EXMEM_BTGT_LSB   = 69;
    localparam int unsigned EXMEM_ALURES_LSB = 37;
    localparam int unsigned EXMEM_WDATA_LSB  = 5;
    localparam int unsigned EXMEM_REGDST_LSB = 0;
    localparam int unsigned EXMEM_REGDST_W   = 5;

    // MEM/WB: MemtoReg, RegWrite, Rdata, ALUresult, Reg_Dst
    localparam int unsigned MEMWB_W            = 71;
    localparam int unsigned MEMWB_MEMTOREG_BIT = 70;
    localparam int unsigned MEMWB_REGWRITE_BIT = 69;
    localparam int unsigned MEMWB_RDATA_LSB    = 37;
    localparam int unsigned MEMWB_RDATA_W      = 32;
    localparam int unsigned MEMWB_ALURES_LSB   = 5;
    localparam int unsigned MEMWB_ALURES_W     = 32;
    localparam int unsigned MEMWB_REGDST_LSB   = 0;
    localparam int unsigned MEMWB_REGDST_W     = 5;

    function automatic logic [MEMWB_W-1:0] memwb_pack(
        input logic        memtoreg,
        input logic        regwrite,
        input logic [31:0] rdata,
        input logic [31:0] alu_result,
        input logic [4:0]  reg_dst
    );
        return {memtoreg, regwrite, rdata, alu_result, reg_dst};
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Enable-loaded payload register with async reset and synchronous clear
// (clear wins over load).
module pipe_data_reg #(
    parameter int unsigned DATA_W = 71
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_q <= '0;
        end else if (i_clr) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid
// buffer and synchronous flush. Ready/valid depend only on registered state.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W       = MEMWB_W,
    parameter bit          CLR_ON_FLUSH = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              in_fire;
    logic              out_fire;
    logic              main_en;
    logic              main_from_skid;
    logic              skid_en;
    logic              data_clr;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;

    assign o_ready  = (state_q != ST_FULL);
    assign o_valid  = (state_q != ST_EMPTY);
    // State encoding equals the number of held entries.
    assign o_count  = state_q;

    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;
    assign data_clr = i_flush & CLR_ON_FLUSH;
    assign main_d   = main_from_skid ? skid_q : i_data;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush overrides every handshake; a coincident out_fire still completes.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_en = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        skid_en = 1'b1;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    pipe_data_reg #(.DATA_W(DATA_W)) u_main (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_clr  (data_clr),
        .i_en   (main_en),
        .i_d    (main_d),
        .o_q    (o_data)
    );

    pipe_data_reg #(.DATA_W(DATA_W)) u_skid (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_clr  (data_clr),
        .i_en   (skid_en),
        .i_d    (i_data),
        .o_q    (skid_q)
    );

endmodule
